fetch_decode_queue: RTL and testbench

FETCH_DECODE_QUEUE -- requirements
Module: fetch_decode_queue

---
 rtl/fetch_decode_queue.sv | 83 ++++++++
 tb/tb_fetch_decode_queue.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_queue.sv
// Fetch-to-decode instruction queue: circular buffer of {pc, instr}
// with combinational field decode of the head entry.
module fetch_decode_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [31:0]              in_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [5:0]               opcode,
  output logic [5:0]               func,
  output logic [4:0]               src_reg1,
  output logic [4:0]               src_reg2,
  output logic [4:0]               dest_reg,
  output logic [4:0]               shamt,
  output logic [XLEN-1:0]          imm,
  output logic [XLEN-1:0]          imm2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            push;
  logic            pop;
  entry_t          head;
  logic [31:0]     h_instr;

  assign in_ready  = count < CW'(DEPTH);
  assign out_valid = count != '0;
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage is not reset; the pointers alone define what is live.
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= '{pc: in_pc, instr: in_instr};
  end

  assign head    = mem[rd_ptr];
  assign h_instr = out_valid ? head.instr : '0;
  assign out_pc  = out_valid ? head.pc : '0;

  assign opcode   = h_instr[31:26];
  assign src_reg1 = h_instr[25:21];
  assign src_reg2 = h_instr[20:16];
  assign dest_reg = h_instr[15:11];
  assign shamt    = h_instr[10:6];
  assign func     = h_instr[5:0];
  assign imm      = {{(XLEN-16){h_instr[15]}}, h_instr[15:0]};
  assign imm2     = {{(XLEN-26){h_instr[25]}}, h_instr[25:0]};

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed + short random bench for fetch_decode_queue with a
// queue scoreboard; a 64-bit instance shares the stimulus.
module tb_fetch_decode_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_instr = '0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid;
  logic [31:0] out_pc, imm, imm2;
  logic [5:0]  opcode, func;
  logic [4:0]  src_reg1, src_reg2, dest_reg, shamt;
  logic [2:0]  count;

  logic        in_ready64, out_valid64;
  logic [63:0] out_pc64, imm64, imm2_64;
  logic [5:0]  opcode64, func64;
  logic [4:0]  sr1_64, sr2_64, dr_64, sh_64;
  logic [2:0]  count64;
  logic [63:0] in_pc64;

  assign in_pc64 = {32'hdead_beef, in_pc};

  always #5 clk = ~clk;

  fetch_decode_queue #(.XLEN(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .opcode(opcode), .func(func),
    .src_reg1(src_reg1), .src_reg2(src_reg2),
    .dest_reg(dest_reg), .shamt(shamt),
    .imm(imm), .imm2(imm2), .count(count)
  );

  fetch_decode_queue #(.XLEN(64), .DEPTH(DEPTH)) dut64 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64),
    .in_pc(in_pc64), .in_instr(in_instr),
    .out_valid(out_valid64), .out_ready(out_ready),
    .out_pc(out_pc64), .opcode(opcode64), .func(func64),
    .src_reg1(sr1_64), .src_reg2(sr2_64),
    .dest_reg(dr_64), .shamt(sh_64),
    .imm(imm64), .imm2(imm2_64), .count(count64)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t q[$];
  int total = 0;
  int bad = 0;

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic        v;
    logic [31:0] i;
    logic [31:0] p;
    v = q.size() > 0;
    i = v ? q[0].instr : 32'h0;
    p = v ? q[0].pc : 32'h0;
    chk("count", 64'(count), 64'(q.size()));
    chk("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
    chk("out_valid", 64'(out_valid), 64'(v));
    chk("out_pc", 64'(out_pc), 64'(p));
    chk("opcode", 64'(opcode), 64'(i[31:26]));
    chk("func", 64'(func), 64'(i[5:0]));
    chk("src_reg1", 64'(src_reg1), 64'(i[25:21]));
    chk("src_reg2", 64'(src_reg2), 64'(i[20:16]));
    chk("dest_reg", 64'(dest_reg), 64'(i[15:11]));
    chk("shamt", 64'(shamt), 64'(i[10:6]));
    chk("imm", 64'(imm), {32'h0, {16{i[15]}}, i[15:0]});
    chk("imm2", 64'(imm2), {32'h0, {6{i[25]}}, i[25:0]});
    chk("count64", 64'(count64), 64'(q.size()));
    chk("out_pc64", out_pc64,
        v ? {32'hdead_beef, p} : 64'h0);
    chk("imm64", imm64, {{48{i[15]}}, i[15:0]});
    chk("imm2_64", imm2_64, {{38{i[25]}}, i[25:0]});
  endtask

  task automatic drive(logic v, logic [31:0] pc,
                       logic [31:0] ins, logic ordy);
    in_valid  = v;
    in_pc     = pc;
    in_instr  = ins;
    out_ready = ordy;
  endtask

  task automatic tick();
    ent_t e;
    bit   do_pop, do_push;
    int   n;
    n = q.size();
    do_pop  = !rst && !flush && out_ready && n > 0;
    do_push = !rst && !flush && in_valid && n < DEPTH;
    if (do_pop) begin
      e = q.pop_front();
      chk("pop_pc", 64'(out_pc), 64'(e.pc));
      chk("pop_func", 64'(func), 64'(e.instr[5:0]));
    end
    if (rst || flush) q.delete();
    if (do_push) q.push_back('{pc: in_pc, instr: in_instr});
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    // reset
    drive(1'b1, 32'h55, 32'hffff_ffff, 1'b1);
    tick();
    tick();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // single push straight out of reset
    rst = 1'b0;
    drive(1'b1, 32'h100, 32'h8C22_FFFC, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    chk("s_valid", 64'(out_valid), 64'd1);
    chk("s_opcode", 64'(opcode), 64'h23);
    chk("s_src1", 64'(src_reg1), 64'd1);
    chk("s_src2", 64'(src_reg2), 64'd2);
    chk("s_dest", 64'(dest_reg), 64'd31);
    chk("s_imm", 64'(imm), 64'hFFFF_FFFC);
    chk("s_count", 64'(count), 64'd1);

    // fill to DEPTH, then hold a fifth offer
    for (int k = 1; k < 4; k++) begin
      drive(1'b1, 32'h100 + 32'(4 * k),
            32'h0400_0000 * k + 32'(k), 1'b0);
      tick();
    end
    chk("full_count", 64'(count), 64'd4);
    chk("full_ready", 64'(in_ready), 64'd0);
    drive(1'b1, 32'h200, 32'h1234_5678, 1'b0);
    tick();
    tick();
    chk("held_count", 64'(count), 64'd4);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("held_acc", 64'(count), 64'd4);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    chk("drained", 64'(out_valid), 64'd0);

    // imm2 sign extension at 32 and 64 bits
    drive(1'b1, 32'h300, 32'h0A00_0000, 1'b0);
    tick();
    chk("imm2_neg", 64'(imm2), 64'hFE00_0000);
    chk("imm2_neg64", imm2_64, 64'hFFFF_FFFF_FE00_0000);
    drive(1'b1, 32'h304, 32'h0800_0001, 1'b1);
    tick();
    chk("imm2_pos", 64'(imm2), 64'h1);
    chk("imm2_pos64", imm2_64, 64'h1);

    // steady push+pop at count=2 across pointer wrap
    drive(1'b1, 32'h308, 32'h0000_0abc, 1'b0);
    tick();
    chk("steady_pre", 64'(count), 64'd2);
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 32'h400 + 32'(4 * k),
            32'h1000_0000 ^ 32'(k * 37), 1'b1);
      tick();
      chk("steady_cnt", 64'(count), 64'd2);
    end

    // flush at count=3 with push and pop requested
    drive(1'b1, 32'h500, 32'h0000_8001, 1'b0);
    tick();
    chk("pre_flush", 64'(count), 64'd3);
    drive(1'b1, 32'h504, 32'h0000_8002, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_cnt", 64'(count), 64'd0);
    chk("flush_pc", 64'(out_pc), 64'd0);

    // reset mid-operation at count=2
    drive(1'b1, 32'h600, 32'h0000_0001, 1'b0);
    tick();
    tick();
    chk("pre_rst", 64'(count), 64'd2);
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_cnt", 64'(count), 64'd0);
    chk("rst_rdy", 64'(in_ready), 64'd1);

    // short random traffic
    for (int k = 0; k < 60; k++) begin
      drive(1'($urandom_range(0, 1)),
            32'h700 + 32'(4 * k), $urandom(),
            1'($urandom_range(0, 1)));
      flush = ($urandom_range(0, 15) == 0);
      tick();
    end
    flush = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
